// File: rtl/led_seq_pkg.sv
// Shared types and seed constants for the LED pattern sequencer.
package led_seq_pkg;

    // Requested / latched pattern mode
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_COUNT   = 2'd1,
        MODE_SHIFT   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Sequencer control state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Direction flag shared by SHIFT (bit position) and BREATHE (duty)
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Values loaded when a new mode is latched
    localparam int unsigned SEED_COUNT     = 0;
    localparam int unsigned SEED_SHIFT_BIT = 0;
    localparam int unsigned SEED_DUTY      = 0;
    localparam logic        SEED_DIR       = DIR_UP;

    // True for modes that light nothing and end in IDLE
    function automatic logic is_off(input mode_e m);
        return m == MODE_OFF;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running prescaler with registered tick and a PWM phase counter.
// wrap_c flags the edge on which the counter wraps so the parent can update
// its pattern on the same edge that raises tick.
module led_seq_prescaler #(
    parameter int unsigned LOG2DELAY = 25,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                wrap_c,
    output logic                tick,
    output logic [PWM_BITS-1:0] phase_next_c
);

    logic [LOG2DELAY-1:0] cnt;
    logic [PWM_BITS-1:0]  phase;

    // Wrap happens on an enabled cycle with the counter at its top value
    assign wrap_c       = enable && (cnt == '1);
    assign phase_next_c = enable ? (phase + PWM_BITS'(1)) : phase;

    // Counter, phase and one-cycle tick pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= wrap_c;
            phase <= phase_next_c;
            if (enable) begin
                cnt <= cnt + LOG2DELAY'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// Prescaled, mode-selectable LED pattern sequencer feeding OBUF / OBUFTDS.
// Mode changes arrive over a valid/ready handshake; a new mode is held in
// SWITCH (outputs dark) until the next prescaler tick aligns the start.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned LOG2DELAY = 25,
    parameter int unsigned NUM_LEDS  = 4,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led,
    output logic                diff_data,
    output logic                diff_t
);

    logic                wrap_c;
    logic [PWM_BITS-1:0] phase_next_c;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [NUM_LEDS-1:0] led_d;
    logic                diff_t_d;
    logic                accept;
    logic                load_seed;
    logic                advance;

    led_seq_prescaler #(
        .LOG2DELAY (LOG2DELAY),
        .PWM_BITS  (PWM_BITS)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wrap_c       (wrap_c),
        .tick         (tick),
        .phase_next_c (phase_next_c)
    );

    // Ready is a pure state decode: only SWITCH refuses requests
    assign mode_ready = (state_q != ST_SWITCH);
    assign accept     = mode_valid && mode_ready;

    // Next-state, pattern update and registered-output decode
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        load_seed = 1'b0;
        advance   = 1'b0;
        led_d     = '0;
        diff_t_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept && !is_off(mode_e'(mode))) begin
                    mode_d    = mode_e'(mode);
                    state_d   = ST_SWITCH;
                    load_seed = 1'b1;
                end
            end
            ST_SWITCH: begin
                // The aligning tick starts the mode but does not advance it
                if (wrap_c) begin
                    state_d = is_off(mode_q) ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A request beats a simultaneous tick; the old advance is lost
                if (accept) begin
                    mode_d    = mode_e'(mode);
                    state_d   = ST_SWITCH;
                    load_seed = 1'b1;
                end else if (wrap_c) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_OFF;
            end
        endcase

        if (load_seed) begin
            pattern_d = (mode_d == MODE_SHIFT) ? (NUM_LEDS'(1) << SEED_SHIFT_BIT)
                                               : NUM_LEDS'(SEED_COUNT);
            duty_d    = PWM_BITS'(SEED_DUTY);
            dir_d     = SEED_DIR;
        end else if (advance) begin
            case (mode_q)
                MODE_COUNT: begin
                    pattern_d = pattern_q + NUM_LEDS'(1);
                end
                MODE_SHIFT: begin
                    // Bounce a single lit bit between the two end positions
                    if (NUM_LEDS == 1) begin
                        pattern_d = NUM_LEDS'(1);
                    end else if (dir_q == DIR_UP) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[NUM_LEDS-1]) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                MODE_BREATHE: begin
                    // Triangle-wave duty, reversing at full scale and zero
                    if (dir_q == DIR_UP) begin
                        duty_d = duty_q + PWM_BITS'(1);
                        if (duty_d == '1) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        duty_d = duty_q - PWM_BITS'(1);
                        if (duty_d == '0) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                default: begin
                    pattern_d = pattern_q;
                end
            endcase
        end

        // Outputs reflect the state and pattern being registered this edge
        if (state_d == ST_RUN) begin
            diff_t_d = 1'b0;
            case (mode_d)
                MODE_COUNT,
                MODE_SHIFT:   led_d = pattern_d;
                MODE_BREATHE: led_d = {NUM_LEDS{phase_next_c < duty_d}};
                default:      led_d = '0;
            endcase
        end
    end

    // State, pattern and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            pattern_q <= '0;
            duty_q    <= '0;
            dir_q     <= DIR_UP;
            led       <= '0;
            diff_data <= 1'b0;
            diff_t    <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            led       <= led_d;
            diff_data <= led_d[0];
            diff_t    <= diff_t_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed table, hand-written corner
// sequences and randomized traffic against a step-count reference model.
module tb_led_pattern_seq;

    localparam int unsigned LOG2DELAY = 2;
    localparam int unsigned NUM_LEDS  = 4;
    localparam int unsigned PWM_BITS  = 3;
    localparam int unsigned PERIOD    = 1 << LOG2DELAY;
    localparam int unsigned PHASES    = 1 << PWM_BITS;
    localparam int unsigned DMAX      = PHASES - 1;
    localparam int unsigned NPAT      = 1 << NUM_LEDS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic [1:0]          mode;
    logic                mode_valid;
    logic                mode_ready;
    logic                tick;
    logic [NUM_LEDS-1:0] led;
    logic                diff_data;
    logic                diff_t;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .LOG2DELAY (LOG2DELAY),
        .NUM_LEDS  (NUM_LEDS),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .tick       (tick),
        .led        (led),
        .diff_data  (diff_data),
        .diff_t     (diff_t)
    );

    // Reference model: state 0 idle / 1 switching / 2 running, k = ticks
    // consumed by the current mode, m_en = enabled cycles since reset.
    int                  m_state, m_mode, m_k, m_en;
    logic [NUM_LEDS-1:0] e_led;
    logic                e_tick, e_dt, e_rdy;

    function automatic logic [NUM_LEDS-1:0] pat(input int md, input int k, input int ph);
        int p, pos, duty;
        case (md)
            1: return NUM_LEDS'(k % NPAT);
            2: begin
                if (NUM_LEDS == 1) return NUM_LEDS'(1);
                p   = k % (2 * (NUM_LEDS - 1));
                pos = (p < NUM_LEDS) ? p : 2 * (NUM_LEDS - 1) - p;
                return NUM_LEDS'(1 << pos);
            end
            3: begin
                p    = k % (2 * DMAX);
                duty = (p <= DMAX) ? p : 2 * DMAX - p;
                return (ph < duty) ? '1 : '0;
            end
            default: return '0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic e, input logic v, input int md);
        logic wrap, acc;
        if (!r) begin
            m_state = 0; m_mode = 0; m_k = 0; m_en = 0; e_tick = 1'b0;
        end else begin
            wrap = e && ((m_en % PERIOD) == PERIOD - 1);
            if (e) m_en++;
            acc = v && (m_state != 1);
            case (m_state)
                0: if (acc && md != 0) begin m_mode = md; m_state = 1; m_k = 0; end
                1: if (wrap) m_state = (m_mode == 0) ? 0 : 2;
                default: begin
                    if (acc) begin m_mode = md; m_state = 1; m_k = 0; end
                    else if (wrap) m_k++;
                end
            endcase
            e_tick = wrap;
        end
        e_led = (m_state == 2) ? pat(m_mode, m_k, m_en % PHASES) : '0;
        e_dt  = (m_state != 2);
        e_rdy = (m_state != 1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, step the model and compare all outputs after the edge
    task automatic cycle(input logic r, input logic e, input logic v, input logic [1:0] md);
        rst_n = r; enable = e; mode_valid = v; mode = md;
        @(posedge clk);
        model_step(r, e, v, int'(md));
        #1;
        chk("m_led",       int'(led),        int'(e_led));
        chk("m_tick",      int'(tick),       int'(e_tick));
        chk("m_diff_data", int'(diff_data),  int'(e_led[0]));
        chk("m_diff_t",    int'(diff_t),     int'(e_dt));
        chk("m_ready",     int'(mode_ready), int'(e_rdy));
    endtask

    typedef struct {
        logic       r, e, v;
        logic [1:0] md;
        logic [3:0] led;
        logic       tk, dt, rdy;
    } vec_t;

    function automatic vec_t mk(input int r, input int e, input int v, input int md,
                                input int ld, input int tk, input int dt, input int rdy);
        vec_t t;
        t.r = 1'(r); t.e = 1'(e); t.v = 1'(v); t.md = 2'(md);
        t.led = 4'(ld); t.tk = 1'(tk); t.dt = 1'(dt); t.rdy = 1'(rdy);
        return t;
    endfunction

    vec_t                tbl [17];
    logic [NUM_LEDS-1:0] shift_got [$];
    logic [NUM_LEDS-1:0] shift_exp [7];
    logic [NUM_LEDS-1:0] held;
    int                  seen;

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode_valid = 1'b0; mode = 2'd0;
        shift_exp = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1};

        // Reset, idle ticking, then a COUNT request and its first advances
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 1, 1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(1, 1, 0, 0, 0, 1, 1, 1);
        tbl[5]  = mk(1, 1, 1, 1, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 1, 0, 1);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 1, 0, 0, 1);
        tbl[14] = mk(1, 1, 0, 0, 1, 0, 0, 1);
        tbl[15] = mk(1, 1, 0, 0, 1, 0, 0, 1);
        tbl[16] = mk(1, 1, 0, 0, 2, 1, 0, 1);

        #2;
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].md);
            chk($sformatf("tbl%0d_led", i),   int'(led),        int'(tbl[i].led));
            chk($sformatf("tbl%0d_tick", i),  int'(tick),       int'(tbl[i].tk));
            chk($sformatf("tbl%0d_dt", i),    int'(diff_t),     int'(tbl[i].dt));
            chk($sformatf("tbl%0d_ready", i), int'(mode_ready), int'(tbl[i].rdy));
        end

        // COUNT up to 5, then OFF arriving on a tick edge: no advance to 6
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0);
        chk("pre_off_led", int'(led), 5);
        cycle(1'b1, 1'b1, 1'b1, 2'd0);
        chk("off_led",   int'(led),        0);
        chk("off_tick",  int'(tick),       1);
        chk("off_ready", int'(mode_ready), 0);
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 2'd0);
            if (tick) seen = 1;
        end
        chk("off_tick_seen", seen, 1);
        chk("off_idle_dt",    int'(diff_t),     1);
        chk("off_idle_ready", int'(mode_ready), 1);

        // SHIFT bounce, collected on every tick from the aligning tick onward
        cycle(1'b1, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 40 && shift_got.size() < 7; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 2'd0);
            if (tick) shift_got.push_back(led);
        end
        chk("shift_ticks", shift_got.size(), 7);
        for (int i = 0; i < shift_got.size(); i++)
            chk($sformatf("shift%0d", i), int'(shift_got[i]), int'(shift_exp[i]));

        // Enable low mid-RUN freezes everything, then a one-edge reset
        held = led;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 2'd0);
            chk("hold_tick", int'(tick), 0);
            chk("hold_led",  int'(led),  int'(held));
        end
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        chk("rst_led",   int'(led),        0);
        chk("rst_tick",  int'(tick),       0);
        chk("rst_dd",    int'(diff_data),  0);
        chk("rst_dt",    int'(diff_t),     1);
        chk("rst_ready", int'(mode_ready), 1);

        // BREATHE across a full up/down duty sweep
        cycle(1'b1, 1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 16 * PERIOD + 12; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0);

        // Randomized requests, enable gaps and occasional resets
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 199) != 0),
                  1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 5) == 0),
                  2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
